// File: rtl/hovalaag_load_sched_if.sv
// Bundles the host loader, CPU and RAM-port signals of the Hovalaag load scheduler.
// The master side drives host/CPU requests; the slave side is the scheduler.
interface hovalaag_load_sched_if;
    logic        host_prog_set;
    logic        host_in1_set;
    logic        host_in2_set;
    logic [12:0] host_addr;
    logic [31:0] host_prog_data;
    logic [11:0] host_in_data;
    logic        run_req;
    logic        cpu_halt;
    logic [7:0]  cpu_pc;
    logic        cpu_in1_rd;
    logic        cpu_in2_rd;

    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [31:0] prog_wdata;
    logic        in1_we;
    logic        in2_we;
    logic [12:0] in1_addr;
    logic [12:0] in2_addr;
    logic [11:0] in_wdata;
    logic        in1_empty;
    logic        in2_empty;
    logic        cpu_rst;
    logic        cpu_run;
    logic        busy;
    logic        done;

    modport master (
        output host_prog_set, host_in1_set, host_in2_set, host_addr,
               host_prog_data, host_in_data, run_req, cpu_halt, cpu_pc,
               cpu_in1_rd, cpu_in2_rd,
        input  prog_we, prog_addr, prog_wdata, in1_we, in2_we, in1_addr,
               in2_addr, in_wdata, in1_empty, in2_empty, cpu_rst, cpu_run,
               busy, done
    );

    modport slave (
        input  host_prog_set, host_in1_set, host_in2_set, host_addr,
               host_prog_data, host_in_data, run_req, cpu_halt, cpu_pc,
               cpu_in1_rd, cpu_in2_rd,
        output prog_we, prog_addr, prog_wdata, in1_we, in2_we, in1_addr,
               in2_addr, in_wdata, in1_empty, in2_empty, cpu_rst, cpu_run,
               busy, done
    );
endinterface

// File: rtl/hovalaag_load_sched.sv
// Arbitrates the program/IN1/IN2 RAM ports between the host loader and the Hovalaag CPU,
// tracks input stream lengths and read pointers, and sequences CPU reset/run.
module hovalaag_load_sched #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned RST_CYCLES    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    hovalaag_load_sched_if.slave  bus
);

    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > RST_CYCLES) ? SETTLE_CYCLES : RST_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CPURST,
        S_RUN
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [13:0]        in1_len_q, in1_len_d;
    logic [13:0]        in2_len_q, in2_len_d;
    logic [13:0]        in1_ptr_q, in1_ptr_d;
    logic [13:0]        in2_ptr_q, in2_ptr_d;
    logic               done_q, done_d;

    logic               any_set;
    logic               running;
    logic               host_owns;
    logic               in1_we, in2_we;
    logic               in1_empty, in2_empty;
    logic [13:0]        addr_plus1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            in1_len_q <= '0;
            in2_len_q <= '0;
            in1_ptr_q <= '0;
            in2_ptr_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            in1_len_q <= in1_len_d;
            in2_len_q <= in2_len_d;
            in1_ptr_q <= in1_ptr_d;
            in2_ptr_q <= in2_ptr_d;
            done_q    <= done_d;
        end
    end

    // A host set during RUN aborts the CPU in the same cycle, so the host owns the ports then too.
    always_comb begin
        any_set    = bus.host_prog_set | bus.host_in1_set | bus.host_in2_set;
        running    = (state_q == S_RUN) && !any_set;
        host_owns  = (state_q != S_CPURST);
        in1_we     = host_owns && bus.host_in1_set;
        in2_we     = host_owns && bus.host_in2_set;
        in1_empty  = (in1_ptr_q == in1_len_q);
        in2_empty  = (in2_ptr_q == in2_len_q);
        addr_plus1 = {1'b0, bus.host_addr} + 14'd1;
    end

    always_comb begin
        bus.prog_we    = host_owns && bus.host_prog_set;
        bus.in1_we     = in1_we;
        bus.in2_we     = in2_we;
        bus.prog_addr  = running ? bus.cpu_pc : bus.host_addr[7:0];
        bus.in1_addr   = running ? in1_ptr_q[12:0] : bus.host_addr;
        bus.in2_addr   = running ? in2_ptr_q[12:0] : bus.host_addr;
        bus.prog_wdata = bus.host_prog_data;
        bus.in_wdata   = bus.host_in_data;
        bus.in1_empty  = in1_empty;
        bus.in2_empty  = in2_empty;
        bus.cpu_run    = running;
        bus.cpu_rst    = !running;
        bus.busy       = (state_q != S_IDLE);
        bus.done       = done_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        in1_len_d = in1_len_q;
        in2_len_d = in2_len_q;
        in1_ptr_d = in1_ptr_q;
        in2_ptr_d = in2_ptr_q;

        if (in1_we && (addr_plus1 > in1_len_q)) in1_len_d = addr_plus1;
        if (in2_we && (addr_plus1 > in2_len_q)) in2_len_d = addr_plus1;

        // Pointers saturate at the stream length; reads outside an active run are dropped.
        if (running && bus.cpu_in1_rd && !in1_empty) in1_ptr_d = in1_ptr_q + 14'd1;
        if (running && bus.cpu_in2_rd && !in2_empty) in2_ptr_d = in2_ptr_q + 14'd1;

        case (state_q)
            S_IDLE: begin
                if (any_set) begin
                    state_d = S_LOAD;
                end else if (bus.run_req) begin
                    state_d   = S_CPURST;
                    cnt_d     = CNT_W'(RST_CYCLES - 1);
                    in1_ptr_d = '0;
                    in2_ptr_d = '0;
                    done_d    = 1'b0;
                end
            end
            S_LOAD: begin
                if (!any_set) begin
                    state_d = S_SETTLE;
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                end
            end
            S_SETTLE: begin
                if (any_set) begin
                    state_d = S_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CPURST: begin
                if (cnt_q == '0) state_d = S_RUN;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_RUN: begin
                if (any_set) begin
                    state_d = S_LOAD;
                end else if (bus.cpu_halt) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
